psram_burst_responder: RTL

- Synthesizable PSRAM device-side model: the responder end of the burst PSRAM bus driven by our PSRAM burst controller.
- Samples CE#/ADV#/OE#/WE#, latches the burst start address, waits a programmable access latency, then streams read data out of, or captures write data into, a small internal word array.
- Used in FPGA loopback builds and simulation benches in place of a real PSRAM part.

---
 rtl/psram_burst_responder.sv | 121 ++++++++++++
 1 files changed

// File: rtl/psram_burst_responder.sv
// Device-side burst PSRAM model. It latches the start address on ADV#, waits a fixed
// access latency, then streams read data out of a small word array or captures write data into it.
module psram_burst_responder #(
    parameter int data_width          = 16,
    parameter int psram_address_width = 23,
    parameter int mem_address_width   = 8,
    parameter int access_latency      = 1,
    parameter int max_burst           = 32
) (
    input  logic                           clk_i,
    input  logic                           rst_i,
    input  logic [psram_address_width-1:0] psram_adr_i,
    input  logic [data_width-1:0]          psram_dat_i,
    output logic [data_width-1:0]          psram_dat_o,
    output logic                           psram_dat_oe,
    input  logic                           psram_ce_n_i,
    input  logic                           psram_adv_n_i,
    input  logic                           psram_oe_n_i,
    input  logic                           psram_we_n_i,
    output logic [8:0]                     beat_count_o,
    output logic                           overrun_o
);

    localparam int DEPTH      = 2 ** mem_address_width;
    localparam int LAT_W      = (access_latency > 1) ? $clog2(access_latency) : 1;
    localparam int LAT_LAST_I = (access_latency > 0) ? access_latency - 1 : 0;
    localparam logic [LAT_W-1:0] LAT_LAST  = LAT_W'(LAT_LAST_I);
    localparam logic [8:0]       MAX_BEATS = 9'(max_burst);

    typedef enum logic [1:0] {IDLE, LATENCY, BURST, DONE} state_t;

    state_t                       state_q;
    logic [mem_address_width-1:0] ptr_q;
    logic [mem_address_width-1:0] ptr_d;
    logic [mem_address_width-1:0] adr_lo;
    logic [LAT_W-1:0]             lat_cnt_q;
    logic [8:0]                   beat_count_q;
    logic [8:0]                   beat_count_d;
    logic                         is_write_q;
    logic                         overrun_q;
    logic [data_width-1:0]        dat_o_q;
    logic                         adv_start;
    logic                         mem_we;
    logic [data_width-1:0]        mem [0:DEPTH-1];
    logic                         unused_adr_hi;

    assign adr_lo        = psram_adr_i[mem_address_width-1:0];
    assign unused_adr_hi = ^psram_adr_i[psram_address_width-1:mem_address_width];
    assign ptr_d         = ptr_q + mem_address_width'(1);
    assign beat_count_d  = beat_count_q + 9'd1;

    // A terminated burst (DONE) ignores ADV# until CE# has gone high.
    assign adv_start = ~psram_ce_n_i & ~psram_adv_n_i & (state_q != DONE);

    assign mem_we = (state_q == BURST) & is_write_q & ~psram_ce_n_i & psram_adv_n_i & ~rst_i;

    always_ff @(posedge clk_i) begin
        if (mem_we) begin
            mem[ptr_q] <= psram_dat_i;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q      <= IDLE;
            ptr_q        <= '0;
            lat_cnt_q    <= '0;
            beat_count_q <= '0;
            is_write_q   <= 1'b0;
            overrun_q    <= 1'b0;
            dat_o_q      <= '0;
        end else if (psram_ce_n_i) begin
            state_q <= IDLE;
        end else if (adv_start) begin
            ptr_q        <= adr_lo;
            is_write_q   <= ~psram_we_n_i;
            lat_cnt_q    <= '0;
            beat_count_q <= '0;
            if (access_latency == 0) begin
                state_q <= BURST;
                dat_o_q <= mem[adr_lo];
            end else begin
                state_q <= LATENCY;
            end
        end else begin
            unique case (state_q)
                IDLE: begin
                end
                LATENCY: begin
                    if (lat_cnt_q == LAT_LAST) begin
                        state_q <= BURST;
                        dat_o_q <= mem[ptr_q];
                    end else begin
                        lat_cnt_q <= lat_cnt_q + LAT_W'(1);
                    end
                end
                BURST: begin
                    // Reads only advance on beats the controller actually takes.
                    if (is_write_q || !psram_oe_n_i) begin
                        ptr_q        <= ptr_d;
                        beat_count_q <= beat_count_d;
                        dat_o_q      <= mem[ptr_d];
                        if (beat_count_d == MAX_BEATS) begin
                            state_q <= DONE;
                        end
                    end
                end
                DONE: begin
                    overrun_q <= 1'b1;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign psram_dat_o  = dat_o_q;
    assign psram_dat_oe = (state_q == BURST) & ~is_write_q & ~psram_ce_n_i & ~psram_oe_n_i;
    assign beat_count_o = beat_count_q;
    assign overrun_o    = overrun_q;

endmodule
